// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             kill;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output kill, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  kill, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one result bit per cycle, signs stripped at accept and re-applied in the last step.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q, lo_q, opnd_q, result_q;
    logic             neg_q, rem_neg_q;

    // Accept-time decode
    logic             a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;

    always_comb begin
        a_signed    = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op[2] && !bus.op[0]);
        b_signed    = (bus.op == 3'b001) || (bus.op[2] && !bus.op[0]);
        sa          = a_signed && bus.a[WIDTH-1];
        sb          = b_signed && bus.b[WIDTH-1];
        a_mag       = sa ? -bus.a : bus.a;
        b_mag       = sb ? -bus.b : bus.b;
        div_zero    = bus.op[2] && (bus.b == '0);
        div_ovf     = bus.op[2] && !bus.op[0] && (bus.a == MinNeg) && (bus.b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else if (div_ovf) begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // One iteration of the datapath; lo_q holds multiplier / dividend-then-quotient
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   acc_step, lo_step, quo_fin, rem_fin, final_res;
    logic [2*WIDTH-1:0] prod, prod_fin;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
                acc_step = div_diff[WIDTH-1:0];
                lo_step  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift[WIDTH-1:0];
                lo_step  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_sum[WIDTH:1];
            lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod     = {acc_step, lo_step};
        prod_fin = neg_q ? -prod : prod;
        quo_fin  = neg_q ? -lo_step : lo_step;
        rem_fin  = rem_neg_q ? -acc_step : acc_step;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (bus.kill) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        cnt_q <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= StDone;
                        end else begin
                            acc_q     <= '0;
                            lo_q      <= bus.op[2] ? a_mag : b_mag;
                            opnd_q    <= bus.op[2] ? b_mag : a_mag;
                            neg_q     <= sa ^ sb;
                            rem_neg_q <= sa;
                            state_q   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    lo_q  <= lo_step;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        result_q <= final_res;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !bus.kill;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, special divides,
// backpressure, back-to-back, kill and mid-op reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Returns the cycle (relative to accept) at which out_valid is first seen; 999 on timeout
    task automatic wait_valid(output int cyc, output bit rdy_seen);
        cyc      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.in_ready) rdy_seen = 1'b1;
        end while (!bus.out_valid && cyc < 100);
        if (!bus.out_valid) cyc = 999;
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_mul_latency();
        int cyc; bit rdy;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_valid(cyc, rdy);
        n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", cyc); end
        n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_busy got %b want 0", rdy); end
        n_tests++; if (bus.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", bus.result); end
        take();
    endtask

    task automatic test_mul_high();
        logic [2:0]  vop [3];
        logic [31:0] va [3], vb [3], vexp [3];
        int cyc; bit rdy;
        vop  = '{3'b001, 3'b011, 3'b010};
        va   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vb   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vexp = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(vop[i], va[i], vb[i]);
            wait_valid(cyc, rdy);
            n_tests++;
            if (bus.result !== vexp[i] || cyc !== 33) begin
                n_fail++;
                $display("FAIL mulh_%0d got %h @%0d want %h @33", i, bus.result, cyc, vexp[i]);
            end
            take();
        end
    endtask

    task automatic test_div();
        logic [2:0]  vop [6];
        logic [31:0] va [6], vb [6], vexp [6];
        int cyc; bit rdy;
        vop  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        va   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        vb   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vexp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
        for (int i = 0; i < 6; i++) begin
            issue(vop[i], va[i], vb[i]);
            wait_valid(cyc, rdy);
            n_tests++;
            if (bus.result !== vexp[i] || cyc !== 33) begin
                n_fail++;
                $display("FAIL div_%0d got %h @%0d want %h @33", i, bus.result, cyc, vexp[i]);
            end
            take();
        end
    endtask

    task automatic test_special();
        logic [2:0]  vop [6];
        logic [31:0] va [6], vb [6], vexp [6];
        int cyc; bit rdy;
        vop  = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
        va   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        vb   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        vexp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            issue(vop[i], va[i], vb[i]);
            wait_valid(cyc, rdy);
            n_tests++;
            if (bus.result !== vexp[i] || cyc !== 1) begin
                n_fail++;
                $display("FAIL special_%0d got %h @%0d want %h @1", i, bus.result, cyc, vexp[i]);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit rdy;
        issue(3'b101, 32'd100, 32'd7);
        wait_valid(cyc, rdy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.result !== 32'd14 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got res=%h ov=%b ir=%b want 0000000e 1 0",
                         i, bus.result, bus.out_valid, bus.in_ready);
            end
        end
        take();
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready); end
        issue(3'b111, 32'd100, 32'd7);
        wait_valid(cyc, rdy);
        n_tests++; if (bus.result !== 32'd2) begin n_fail++; $display("FAIL after_release got %h want 2", bus.result); end
        take();
    endtask

    task automatic test_back_to_back();
        int cyc; bit rdy;
        issue(3'b101, 32'd100, 32'd7);
        wait_valid(cyc, rdy);
        // Request waits on the handshake edge; accepted only on the edge after
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'b000;
        bus.a         = 32'd3;
        bus.b         = 32'd5;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        n_tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got busy=%b ir=%b want 0 1", bus.busy, bus.in_ready); end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_valid(cyc, rdy);
        n_tests++;
        if (bus.result !== 32'd15 || cyc !== 33) begin
            n_fail++;
            $display("FAIL b2b_result got %h @%0d want 0000000f @33", bus.result, cyc);
        end
        take();
    endtask

    task automatic test_kill();
        int cyc; bit rdy; bit seen;
        issue(3'b000, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL kill_in_ready got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1 bus.kill = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'd15) begin
            n_fail++;
            $display("FAIL kill_state got busy=%b ov=%b res=%h want 0 0 0000000f",
                     bus.busy, bus.out_valid, bus.result);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_output got %b want 0", seen); end
        // Kill while idle must block the accept
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 32'd1; bus.b = 32'd1; bus.kill = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL kill_idle_ready got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1 begin bus.in_valid = 1'b0; bus.kill = 1'b0; end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_accept got busy=%b want 0", bus.busy); end
        issue(3'b011, 32'd3, 32'd5);
        wait_valid(cyc, rdy);
        n_tests++; if (bus.result !== 32'd0 || cyc !== 33) begin n_fail++; $display("FAIL mulhu_after_kill got %h @%0d want 0 @33", bus.result, cyc); end
        take();
    endtask

    task automatic test_rst_mid();
        int cyc; bit rdy; bit seen;
        issue(3'b100, 32'd100, 32'd3);
        repeat (19) @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid got busy=%b ov=%b res=%h want 0 0 0", bus.busy, bus.out_valid, bus.result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_output got %b want 0", seen); end
        issue(3'b000, 32'd3, 32'd5);
        wait_valid(cyc, rdy);
        n_tests++; if (bus.result !== 32'd15 || cyc !== 33) begin n_fail++; $display("FAIL mul_after_rst got %h @%0d want 0000000f @33", bus.result, cyc); end
        take();
    endtask

    initial begin
        bus.kill      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_div();
        test_special();
        test_backpressure();
        test_back_to_back();
        test_kill();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
